instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  IF stage plus IF/ID pipeline register. Feeds instruction_decode.
//  Holds the PC and issues requests to instruction memory over a req/ready handshake.
//  Presents instruction, PC and PC+4 (the link value for BL) to ID.
//  Handles hazard-unit stalls and branch redirects from EX/MEM; a redirect flushes IF/ID to a NOP.
// PARAMETERS
//  RESET_PC   64'h0          PC fetched first after reset
//  NOP_INSTR  32'hD503201F   ARMv8 NOP, loaded into IF/ID on reset/flush
// PORTS
//  clock               in   1   single clock, rising edge
//  reset               in   1   synchronous, active-low
//  stall               in   1   hazard unit: hold IF/ID and PC
//  PCSrc               in   1   branch taken: redirect + flush
//  branch_target       in   64  redirect address, valid when PCSrc=1
//  imem_req            out  1   fetch request (registered)
//  imem_addr           out  64  fetch address = pc register
//  imem_ready          in   1   memory returns imem_rdata this cycle
//  imem_rdata          in   32  fetched instruction word
//  instruction         out  32  IF/ID instruction to ID
//  PC_out              out  64  IF/ID PC of that instruction
//  PC_branch_link_out  out  64  IF/ID PC+4, link value for BL
//  if_id_valid         out  1   IF/ID holds a real (non-bubble) instruction
// BEHAVIOUR
//  Reset (reset==0 at a clock edge):
//   - pc=RESET_PC, state=IDLE, imem_req=0
//   - instruction=NOP_INSTR, PC_out=0, PC_branch_link_out=0, if_id_valid=0
//   - skid buffer empty, redirect_pending=0
//   - Reset mid-request: outstanding data is abandoned.
//  States:
//   IDLE: one cycle after reset release -> FETCH (imem_req=1).
//   FETCH: imem_req=1, imem_addr=pc. imem_addr and imem_req are held stable until imem_ready.
//    - ready & PCSrc: drop data, pc<=branch_target, stay FETCH.
//    - ready & !stall: IF/ID<={rdata, pc, pc+4, valid=1}, pc<=pc+4, stay FETCH.
//    - ready & stall: skid<={rdata, pc}, pc<=pc+4, imem_req<=0, -> HOLD.
//    - !ready & PCSrc: latch target, redirect_pending=1, -> DRAIN.
//   DRAIN: imem_req stays 1, old address held.
//    - On ready: drop data, pc<=latched target, -> FETCH (new address next cycle).
//    - A further PCSrc overwrites the latched target.
//   HOLD: imem_req=0.
//    - PCSrc: drop skid, pc<=branch_target, -> FETCH.
//    - !stall: IF/ID<=skid (valid=1), -> FETCH.
//  IF/ID priority: PCSrc (flush) > stall (hold) > load.
//   - Flush: instruction=NOP_INSTR, if_id_valid=0; PC fields unchanged.
//   - No load in a cycle without flush or hold: IF/ID becomes a bubble (valid=0).
//  Arithmetic and latency:
//   - pc increments by 4, mod 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
//   - PC_branch_link_out = PC_out+4, same wrap.
//   - Zero-wait memory (ready same cycle as req): 1 instr/cycle; IF/ID updates at the edge after ready.
//   - PCSrc -> first target instr in IF/ID: 2 cycles with zero-wait memory.
//  imem_ready while imem_req=0 is ignored.
// TESTING
//  1. Reset low 2 cycles, release, imem_ready=1 always:
//     imem_req rises 1 cycle after release; addr 0,4,8,...
//     IF/ID PC_out 0,4,8 with PC_branch_link_out 4,8,12; valid=1 from 3rd cycle.
//  2. stall=1 for 3 cycles mid-stream at pc=0x10:
//     0x10 goes to skid; IF/ID holds 0x0C; imem_req=0.
//     On release IF/ID gets 0x10, next fetch 0x14; no instruction lost or duplicated.
//  3. PCSrc=1, branch_target=0x100 while fetching 0x20 with ready=1:
//     IF/ID=NOP, valid=0; 0x20 data dropped; next imem_addr=0x100.
//  4. PCSrc at 0x40 with ready low 3 more cycles:
//     imem_addr stays 0x40 until ready; that data is dropped; then addr=target.
//  5. Redirect while in HOLD: skid discarded, addr=target next cycle; stall+PCSrc same cycle -> flush wins.
//  6. RESET_PC=64'hFFFF_FFFF_FFFF_FFF8: fetch addresses ...FFF8, ...FFFC, 0x0.
//     Reset asserted mid-DRAIN -> all outputs return to reset values.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage holding the PC, fetching over an imem req/ready handshake
// into the IF/ID register, with a one-entry skid buffer for stalls and a drain state for redirects.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [63:0] branch_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] PC_out,
    output logic [63:0] PC_branch_link_out,
    output logic        if_id_valid
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;
    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] tgt_q, tgt_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        req_q, req_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_out_q, pc_out_d;
    logic [63:0] link_q, link_d;
    logic        valid_q, valid_d;
    logic        load;
    logic [31:0] load_instr;
    logic [63:0] load_pc;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        req_d        = req_q;
        load         = 1'b0;
        load_instr   = imem_rdata;
        load_pc      = pc_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                if (imem_ready) begin
                    pc_d = PCSrc ? branch_target : pc_q + 64'd4;
                    if (!PCSrc && stall) begin
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        req_d        = 1'b0;
                        state_d      = HOLD;
                    end else begin
                        load = !PCSrc;
                    end
                end else if (PCSrc) begin
                    tgt_d   = branch_target;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // The outstanding request must complete before the new address can be issued.
                tgt_d = PCSrc ? branch_target : tgt_q;
                if (imem_ready) begin
                    pc_d    = PCSrc ? branch_target : tgt_q;
                    state_d = FETCH;
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    pc_d    = branch_target;
                    req_d   = 1'b1;
                    state_d = FETCH;
                end else if (!stall) begin
                    load       = 1'b1;
                    load_instr = skid_instr_q;
                    load_pc    = skid_pc_q;
                    req_d      = 1'b1;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
        instr_d  = PCSrc ? NOP_INSTR : load ? load_instr : instr_q;
        valid_d  = PCSrc ? 1'b0 : stall ? valid_q : load;
        pc_out_d = load ? load_pc : pc_out_q;
        link_d   = load ? load_pc + 64'd4 : link_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            req_q        <= 1'b0;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= '0;
            link_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            req_q        <= req_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            link_q       <= link_d;
            valid_q      <= valid_d;
        end
    end
    assign imem_req           = req_q;
    assign imem_addr          = pc_q;
    assign instruction        = instr_q;
    assign PC_out             = pc_out_q;
    assign PC_branch_link_out = link_q;
    assign if_id_valid        = valid_q;
endmodule
